// File: rtl/tank_pkg.sv
// Shared keycodes, direction encoding and held-set types for the tank keyboard path.
package tank_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned DIR_N = 4;

  localparam logic [KEY_W-1:0] KC_NONE     = 8'd0;
  localparam logic [KEY_W-1:0] KC_ROLLOVER = 8'd1;

  localparam logic [KEY_W-1:0] KC_P1_UP    = 8'd26;
  localparam logic [KEY_W-1:0] KC_P1_DOWN  = 8'd22;
  localparam logic [KEY_W-1:0] KC_P1_LEFT  = 8'd4;
  localparam logic [KEY_W-1:0] KC_P1_RIGHT = 8'd7;
  localparam logic [KEY_W-1:0] KC_P1_FIRE  = 8'd44;

  localparam logic [KEY_W-1:0] KC_P2_UP    = 8'd82;
  localparam logic [KEY_W-1:0] KC_P2_DOWN  = 8'd81;
  localparam logic [KEY_W-1:0] KC_P2_LEFT  = 8'd80;
  localparam logic [KEY_W-1:0] KC_P2_RIGHT = 8'd79;
  localparam logic [KEY_W-1:0] KC_P2_FIRE  = 8'd40;

  // Matches the tank direction port; the value doubles as the held-set bit index.
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef logic [DIR_N-1:0] held_t;
  typedef logic [DIR_N-1:0][KEY_W-1:0] code_tbl_t;

  localparam code_tbl_t P1_CODES = {KC_P1_UP, KC_P1_DOWN, KC_P1_RIGHT, KC_P1_LEFT};
  localparam code_tbl_t P2_CODES = {KC_P2_UP, KC_P2_DOWN, KC_P2_RIGHT, KC_P2_LEFT};

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_COMMIT  = 1'b1
  } kr_state_e;

  function automatic held_t decode_dir(input logic [KEY_W-1:0] kc, input code_tbl_t tbl);
    held_t d;
    d = '0;
    for (int i = 0; i < DIR_N; i++) d[i] = (kc == tbl[i]);
    return d;
  endfunction

  // Priority up > down > left > right; result is don't-care for an empty set.
  function automatic dir_e top_dir(input held_t s);
    if (s[DIR_UP])        return DIR_UP;
    else if (s[DIR_DOWN]) return DIR_DOWN;
    else if (s[DIR_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/player_key_arbiter.sv
// Per-player last-pressed-wins arbiter with frame-latched keycode and fire outputs.
// Fire logic exists only when KEY_ROUTER_FIRE_EN is defined.
module player_key_arbiter
  import tank_pkg::*;
#(
  parameter code_tbl_t CODES = P1_CODES
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  held_t            shadow_dir,
`ifdef KEY_ROUTER_FIRE_EN
  input  logic             shadow_fire,
  output logic             fire,
`endif
  input  logic             commit,
  input  logic             frame_tick,
  output logic [KEY_W-1:0] keycode
);

  held_t held;
  logic  active_vld;
  dir_e  active_dir;

  held_t newly;
  logic  act_vld_nxt;
  dir_e  act_dir_nxt;

  // Newest press wins; otherwise keep the current key while it stays down.
  always_comb begin
    newly       = shadow_dir & ~held;
    act_vld_nxt = active_vld;
    act_dir_nxt = active_dir;
    if (|newly) begin
      act_vld_nxt = 1'b1;
      act_dir_nxt = top_dir(newly);
    end else if (!(active_vld && shadow_dir[active_dir])) begin
      act_vld_nxt = |shadow_dir;
      act_dir_nxt = top_dir(shadow_dir);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      held       <= '0;
      active_vld <= 1'b0;
      active_dir <= DIR_LEFT;
      keycode    <= '0;
    end else begin
      if (commit) begin
        held       <= shadow_dir;
        active_vld <= act_vld_nxt;
        active_dir <= act_dir_nxt;
      end
      if (frame_tick) keycode <= active_vld ? CODES[active_dir] : KC_NONE;
    end
  end

`ifdef KEY_ROUTER_FIRE_EN
  logic fire_held;
  logic fire_pend;

  // A press edge committed alongside a tick wins over the tick's clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_held <= 1'b0;
      fire_pend <= 1'b0;
      fire      <= 1'b0;
    end else begin
      if (commit) fire_held <= shadow_fire;
      if (commit && shadow_fire && !fire_held) fire_pend <= 1'b1;
      else if (frame_tick)                     fire_pend <= 1'b0;
      if (frame_tick) fire <= fire_pend;
    end
  end
`endif

endmodule

// File: rtl/key_router.sv
// HID boot-report slot collector feeding two player arbiters.
// Define KEY_ROUTER_FIRE_EN to build fire decoding and fire outputs.
module key_router
  import tank_pkg::*;
#(
  parameter int unsigned REPORT_SLOTS = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [KEY_W-1:0] key_data,
  input  logic             key_valid,
  input  logic             key_last,
  output logic             key_ready,
  input  logic             frame_tick,
  output logic [KEY_W-1:0] keycode_p1,
  output logic [KEY_W-1:0] keycode_p2,
  output logic             fire_p1,
  output logic             fire_p2,
  output logic             report_err
);

  localparam int unsigned CNT_W    = 3;
  localparam logic [CNT_W-1:0] SLOT_LIM = CNT_W'(REPORT_SLOTS);

  kr_state_e        state;
  kr_state_e        state_nxt;
  logic [CNT_W-1:0] slot_cnt;
  logic             rollover;
  held_t            shadow_p1;
  held_t            shadow_p2;

  logic  accept;
  logic  take;
  logic  commit;
  logic  commit_ok;
  held_t slot_p1;
  held_t slot_p2;

  assign accept    = key_valid && key_ready;
  assign take      = accept && (slot_cnt < SLOT_LIM);
  assign commit    = (state == ST_COMMIT);
  assign commit_ok = commit && !rollover;
  assign slot_p1   = decode_dir(key_data, P1_CODES);
  assign slot_p2   = decode_dir(key_data, P2_CODES);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (accept && key_last) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_COLLECT;
      key_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      key_ready <= (state_nxt == ST_COLLECT);
    end
  end

  // Shadow accumulation; COMMIT hands the shadow to the arbiters and clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_cnt   <= '0;
      rollover   <= 1'b0;
      shadow_p1  <= '0;
      shadow_p2  <= '0;
      report_err <= 1'b0;
    end else if (commit) begin
      slot_cnt  <= '0;
      rollover  <= 1'b0;
      shadow_p1 <= '0;
      shadow_p2 <= '0;
      if (rollover) report_err <= 1'b1;
    end else if (take) begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
      shadow_p1 <= shadow_p1 | slot_p1;
      shadow_p2 <= shadow_p2 | slot_p2;
      if (key_data == KC_ROLLOVER) rollover <= 1'b1;
    end
  end

`ifdef KEY_ROUTER_FIRE_EN
  logic shadow_f1;
  logic shadow_f2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_f1 <= 1'b0;
      shadow_f2 <= 1'b0;
    end else if (commit) begin
      shadow_f1 <= 1'b0;
      shadow_f2 <= 1'b0;
    end else if (take) begin
      if (key_data == KC_P1_FIRE) shadow_f1 <= 1'b1;
      if (key_data == KC_P2_FIRE) shadow_f2 <= 1'b1;
    end
  end

  player_key_arbiter #(.CODES(P1_CODES)) u_arb_p1 (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .shadow_dir  (shadow_p1),
    .shadow_fire (shadow_f1),
    .fire        (fire_p1),
    .commit      (commit_ok),
    .frame_tick  (frame_tick),
    .keycode     (keycode_p1)
  );

  player_key_arbiter #(.CODES(P2_CODES)) u_arb_p2 (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .shadow_dir  (shadow_p2),
    .shadow_fire (shadow_f2),
    .fire        (fire_p2),
    .commit      (commit_ok),
    .frame_tick  (frame_tick),
    .keycode     (keycode_p2)
  );
`else
  assign fire_p1 = 1'b0;
  assign fire_p2 = 1'b0;

  player_key_arbiter #(.CODES(P1_CODES)) u_arb_p1 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .shadow_dir (shadow_p1),
    .commit     (commit_ok),
    .frame_tick (frame_tick),
    .keycode    (keycode_p1)
  );

  player_key_arbiter #(.CODES(P2_CODES)) u_arb_p2 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .shadow_dir (shadow_p2),
    .commit     (commit_ok),
    .frame_tick (frame_tick),
    .keycode    (keycode_p2)
  );
`endif

endmodule
